exe_stage_vec: RTL and testbench

// Parametrised execute stage: scalar ALU, NUM_LANES-wide vector ALU, branch resolution, LD/ST address generation.

---
 rtl/exe_stage_vec.sv | 246 ++++++++++++++++++++++++
 tb/tb_exe_stage_vec.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_vec.sv
// ---------------------------------------------------------------------------
// exe_stage_vec
//
// Execute stage between decode (DE) and memory (MEM). It contains:
//   - a scalar ALU: ADD, AND, MOV, CMP
//   - a NUM_LANES-wide vector ALU: VADD, VMOV
//   - branch resolution, which drives a combinational redirect to the front-end
//   - LD/ST address generation
//   - a multi-cycle multiplier (MUL) with a latency of MUL_CYCLES
//
// All state changes on the falling edge of I_CLOCK. I_RESET_N is an
// asynchronous, active-low reset.
//
// Handshake (valid/ready):
//   A transfer from DE happens on an active edge where I_Valid and O_Ready
//   are both high. O_Ready is combinational. O_Ready is high only when the
//   FSM is in RUN and the output register can advance. The output register
//   advances when it is empty (!O_Valid) or when MEM is not stalling
//   (!I_DownStall). While MEM stalls a valid result, every registered output
//   holds its value.
//
// Ports:
//   I_CLOCK, I_RESET_N            clock (negedge active), async active-low reset
//   I_Valid / O_Ready             DE handshake
//   I_AluOp, I_UseImm             opcode, immediate select for operand B
//   I_Src1, I_Src2, I_Imm         scalar operands
//   I_VecSrc1, I_VecSrc2          vector operands, lane 0 in the LSBs
//   I_DestIdx, I_PC               destination index, instruction PC
//   I_CCMask, I_CCValue           branch condition mask, current CC {N,Z,P}
//   I_DownStall                   MEM cannot take a new result
//   O_Valid .. O_MDRValue         registered result and write enables to MEM
//   O_BranchTaken_Signal          combinational redirect request
//   O_BranchPC_Signal             combinational target, I_PC + I_Imm
//   O_DbgState                    current FSM state (0 = RUN, 1 = MUL_BUSY)
// ---------------------------------------------------------------------------
module exe_stage_vec #(
  parameter int REG_WIDTH  = 16,
  parameter int LANE_WIDTH = 16,
  parameter int NUM_LANES  = 4,
  parameter int PC_WIDTH   = 16,
  parameter int MUL_CYCLES = 4
) (
  input  logic                            I_CLOCK,
  input  logic                            I_RESET_N,
  input  logic                            I_Valid,
  output logic                            O_Ready,
  input  logic [3:0]                      I_AluOp,
  input  logic                            I_UseImm,
  input  logic [REG_WIDTH-1:0]            I_Src1,
  input  logic [REG_WIDTH-1:0]            I_Src2,
  input  logic [REG_WIDTH-1:0]            I_Imm,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] I_VecSrc1,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] I_VecSrc2,
  input  logic [3:0]                      I_DestIdx,
  input  logic [PC_WIDTH-1:0]             I_PC,
  input  logic [2:0]                      I_CCMask,
  input  logic [2:0]                      I_CCValue,
  input  logic                            I_DownStall,
  output logic                            O_Valid,
  output logic [3:0]                      O_DestIdx,
  output logic [REG_WIDTH-1:0]            O_DestValue,
  output logic [NUM_LANES*LANE_WIDTH-1:0] O_VecDestValue,
  output logic                            O_RegWEn,
  output logic                            O_VRegWEn,
  output logic                            O_CCWEn,
  output logic [2:0]                      O_CCValue,
  output logic [REG_WIDTH-1:0]            O_MARValue,
  output logic [REG_WIDTH-1:0]            O_MDRValue,
  output logic                            O_BranchTaken_Signal,
  output logic [PC_WIDTH-1:0]             O_BranchPC_Signal,
  output logic [0:0]                      O_DbgState
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_MOV  = 4'd2;
  localparam logic [3:0] OP_CMP  = 4'd3;
  localparam logic [3:0] OP_VADD = 4'd4;
  localparam logic [3:0] OP_VMOV = 4'd5;
  localparam logic [3:0] OP_LD   = 4'd6;
  localparam logic [3:0] OP_ST   = 4'd7;
  localparam logic [3:0] OP_BR   = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MUL_BUSY = 1'b1;

  localparam int            CW        = $clog2(MUL_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_START = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(1);

  logic [0:0]                      state;
  logic [CW-1:0]                   mul_cnt;
  logic [REG_WIDTH-1:0]            mul_a;
  logic [REG_WIDTH-1:0]            mul_b;
  logic [3:0]                      mul_dest;
  logic [REG_WIDTH-1:0]            mul_prod;

  logic                            adv;
  logic                            accept;
  logic                            mul_done;
  logic [REG_WIDTH-1:0]            op_b;
  logic [REG_WIDTH-1:0]            addr_sum;
  logic [2:0]                      cmp_cc;
  logic [NUM_LANES*LANE_WIDTH-1:0] vec_sum;

  assign O_DbgState = state;

  assign adv      = !O_Valid || !I_DownStall;
  assign O_Ready  = (state == ST_RUN) && adv;
  assign accept   = I_Valid && O_Ready;
  assign mul_done = (state == ST_MUL_BUSY) && (mul_cnt == CNT_LAST) && adv;

  assign op_b     = I_UseImm ? I_Imm : I_Src2;
  assign addr_sum = I_Src1 + I_Imm;
  // Only the low REG_WIDTH bits of the product are kept.
  assign mul_prod = mul_a * mul_b;

  // The redirect depends on accept, so a stalled or busy stage never redirects.
  assign O_BranchTaken_Signal = accept && (I_AluOp == OP_BR) && (|(I_CCMask & I_CCValue));
  assign O_BranchPC_Signal    = I_PC + PC_WIDTH'(I_Imm);

  always_comb begin
    cmp_cc = 3'b001;
    if ($signed(I_Src1) < $signed(op_b)) begin
      cmp_cc = 3'b100;
    end else if (I_Src1 == op_b) begin
      cmp_cc = 3'b010;
    end
  end

  // Each lane adds on its own, so a carry never crosses into the next lane.
  always_comb begin
    vec_sum = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      vec_sum[i*LANE_WIDTH +: LANE_WIDTH] = I_VecSrc1[i*LANE_WIDTH +: LANE_WIDTH]
                                          + I_VecSrc2[i*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  // FSM and multiplier operand latches
  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state    <= ST_RUN;
      mul_cnt  <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      mul_dest <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (accept && (I_AluOp == OP_MUL)) begin
            state    <= ST_MUL_BUSY;
            mul_cnt  <= CNT_START;
            mul_a    <= I_Src1;
            mul_b    <= op_b;
            mul_dest <= I_DestIdx;
          end
        end
        ST_MUL_BUSY: begin
          // Count down to 1, then wait there until the output register can take the product.
          if (mul_cnt > CNT_LAST) begin
            mul_cnt <= mul_cnt - CNT_LAST;
          end else if (adv) begin
            state   <= ST_RUN;
            mul_cnt <= '0;
          end
        end
        default: begin
          state   <= ST_RUN;
          mul_cnt <= '0;
        end
      endcase
    end
  end

  // Output register. A result field is updated only by ops that produce it.
  // Every other field keeps its last value.
  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      O_Valid        <= 1'b0;
      O_DestIdx      <= '0;
      O_DestValue    <= '0;
      O_VecDestValue <= '0;
      O_RegWEn       <= 1'b0;
      O_VRegWEn      <= 1'b0;
      O_CCWEn        <= 1'b0;
      O_CCValue      <= '0;
      O_MARValue     <= '0;
      O_MDRValue     <= '0;
    end else if (adv) begin
      O_Valid   <= 1'b0;
      O_RegWEn  <= 1'b0;
      O_VRegWEn <= 1'b0;
      O_CCWEn   <= 1'b0;
      if (mul_done) begin
        O_Valid     <= 1'b1;
        O_DestIdx   <= mul_dest;
        O_DestValue <= mul_prod;
        O_RegWEn    <= 1'b1;
      end else if (accept && (I_AluOp != OP_MUL)) begin
        O_Valid   <= 1'b1;
        O_DestIdx <= I_DestIdx;
        case (I_AluOp)
          OP_ADD: begin
            O_DestValue <= I_Src1 + op_b;
            O_RegWEn    <= 1'b1;
          end
          OP_AND: begin
            O_DestValue <= I_Src1 & op_b;
            O_RegWEn    <= 1'b1;
          end
          OP_MOV: begin
            O_DestValue <= op_b;
            O_RegWEn    <= 1'b1;
          end
          OP_CMP: begin
            O_CCValue <= cmp_cc;
            O_CCWEn   <= 1'b1;
          end
          OP_VADD: begin
            O_VecDestValue <= vec_sum;
            O_VRegWEn      <= 1'b1;
          end
          OP_VMOV: begin
            O_VecDestValue <= I_VecSrc1;
            O_VRegWEn      <= 1'b1;
          end
          OP_LD: begin
            // MEM fills the load data, so only the address is produced here.
            O_MARValue <= addr_sum;
            O_RegWEn   <= 1'b1;
          end
          OP_ST: begin
            O_MARValue <= addr_sum;
            O_MDRValue <= I_Src2;
          end
          default: begin
            // BR and NOP give a valid result with no write enables.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exe_stage_vec.sv
module tb_exe_stage_vec;
  localparam int MUL_CYCLES = 4;

  logic        clk;
  logic        rst_n;
  logic        vld;
  logic        ready;
  logic [3:0]  op;
  logic        useimm;
  logic [15:0] src1, src2, imm;
  logic [63:0] vs1, vs2;
  logic [3:0]  dest;
  logic [15:0] pc;
  logic [2:0]  mask, cc;
  logic        stall;
  logic        o_valid;
  logic [3:0]  o_dest;
  logic [15:0] o_val;
  logic [63:0] o_vec;
  logic        o_reg, o_vreg, o_ccw;
  logic [2:0]  o_cc;
  logic [15:0] o_mar, o_mdr;
  logic        o_taken;
  logic [15:0] o_bpc;
  logic [0:0]  o_state;

  exe_stage_vec #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .I_CLOCK(clk), .I_RESET_N(rst_n), .I_Valid(vld), .O_Ready(ready),
    .I_AluOp(op), .I_UseImm(useimm), .I_Src1(src1), .I_Src2(src2), .I_Imm(imm),
    .I_VecSrc1(vs1), .I_VecSrc2(vs2), .I_DestIdx(dest), .I_PC(pc),
    .I_CCMask(mask), .I_CCValue(cc), .I_DownStall(stall),
    .O_Valid(o_valid), .O_DestIdx(o_dest), .O_DestValue(o_val), .O_VecDestValue(o_vec),
    .O_RegWEn(o_reg), .O_VRegWEn(o_vreg), .O_CCWEn(o_ccw), .O_CCValue(o_cc),
    .O_MARValue(o_mar), .O_MDRValue(o_mdr),
    .O_BranchTaken_Signal(o_taken), .O_BranchPC_Signal(o_bpc), .O_DbgState(o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int n_cmp = 0;
  logic last_ready, last_taken;

  // reference model: expected registered outputs plus the pending multiply
  logic        e_valid, e_reg, e_vreg, e_ccw;
  logic [3:0]  e_dest;
  logic [15:0] e_val, e_mar, e_mdr;
  logic [63:0] e_vec;
  logic [2:0]  e_cc;
  logic        m_busy;
  int          m_elapsed;
  logic [15:0] m_val;
  logic [3:0]  m_dest;

  // scoreboard: expected values for the redirect signals, checked in order
  logic [15:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_valid = 0; e_reg = 0; e_vreg = 0; e_ccw = 0; e_dest = 0; e_val = 0;
    e_mar = 0; e_mdr = 0; e_vec = 0; e_cc = 0;
    m_busy = 0; m_elapsed = 0; m_val = 0; m_dest = 0;
  endtask

  // One active clock edge, computed from the op rules.
  task automatic model_edge();
    logic adv, acc, deliver;
    logic [15:0] b;
    logic [31:0] prod;
    adv = !e_valid || !stall;
    acc = vld && !m_busy && adv;
    b = useimm ? imm : src2;
    deliver = 1'b0;
    if (m_busy) begin
      m_elapsed++;
      deliver = (m_elapsed >= MUL_CYCLES - 1) && adv;
    end
    if (adv) begin
      e_valid = 0; e_reg = 0; e_vreg = 0; e_ccw = 0;
      if (deliver) begin
        e_valid = 1; e_dest = m_dest; e_val = m_val; e_reg = 1; m_busy = 0;
      end else if (acc) begin
        if (op == 4'd9) begin
          prod = 32'(src1) * 32'(b);
          m_busy = 1; m_elapsed = 0; m_val = prod[15:0]; m_dest = dest;
        end else begin
          e_valid = 1; e_dest = dest;
          case (op)
            4'd0: begin e_val = src1 + b; e_reg = 1; end
            4'd1: begin e_val = src1 & b; e_reg = 1; end
            4'd2: begin e_val = b; e_reg = 1; end
            4'd3: begin
              if ($signed(src1) < $signed(b)) e_cc = 3'b100;
              else if (src1 == b) e_cc = 3'b010;
              else e_cc = 3'b001;
              e_ccw = 1;
            end
            4'd4: begin
              for (int i = 0; i < 4; i++) e_vec[16*i +: 16] = vs1[16*i +: 16] + vs2[16*i +: 16];
              e_vreg = 1;
            end
            4'd5: begin e_vec = vs1; e_vreg = 1; end
            4'd6: begin e_mar = src1 + imm; e_reg = 1; end
            4'd7: begin e_mar = src1 + imm; e_mdr = src2; end
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic check_comb();
    logic m_ready, m_taken;
    m_ready = !m_busy && (!e_valid || !stall);
    m_taken = vld && m_ready && (op == 4'd8) && ((mask & cc) != 3'b000);
    exp_q.push_back({15'd0, m_taken});
    exp_q.push_back(pc + imm);
    chk("ready", ready, m_ready);
    chk("taken", o_taken, exp_q.pop_front());
    chk("br_pc", o_bpc, exp_q.pop_front());
  endtask

  task automatic check_regs();
    chk("valid", o_valid, e_valid);
    chk("dest_idx", o_dest, e_dest);
    chk("dest_val", o_val, e_val);
    chk("vec_val", o_vec, e_vec);
    chk("reg_wen", o_reg, e_reg);
    chk("vreg_wen", o_vreg, e_vreg);
    chk("cc_wen", o_ccw, e_ccw);
    chk("cc_val", o_cc, e_cc);
    chk("mar", o_mar, e_mar);
    chk("mdr", o_mdr, e_mdr);
    chk("busy", o_state, m_busy);
  endtask

  // Inputs are applied just after a posedge. One call covers one full cycle.
  task automatic tick();
    #1;
    check_comb();
    last_ready = ready;
    last_taken = o_taken;
    @(negedge clk);
    model_edge();
    @(posedge clk);
    check_regs();
    vectors++;
  endtask

  // driver tasks
  task automatic issue(input logic [3:0] o, input logic ui, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] im);
    vld = 1; op = o; useimm = ui; src1 = a; src2 = b; imm = im; dest = 4'($urandom_range(0, 15));
  endtask

  task automatic idle();
    vld = 0; op = 4'd15;
  endtask

  initial begin
    rst_n = 0; vld = 0; op = 0; useimm = 0; src1 = 0; src2 = 0; imm = 0;
    vs1 = 0; vs2 = 0; dest = 0; pc = 0; mask = 0; cc = 0; stall = 0;
    model_reset();
    @(posedge clk);
    check_regs();
    #1;
    check_comb();
    chk("rst_ready", ready, 1'b1);
    rst_n = 1;
    @(posedge clk);

    // Reset during the second busy cycle of a MUL discards the pending product.
    issue(4'd9, 1'b0, 16'd7, 16'd9, 16'd0);
    tick();
    idle();
    tick();
    rst_n = 0;
    model_reset();
    #1;
    check_regs();
    #1;
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_mul_valid", o_valid, 1'b0);
      chk("rst_mul_ready", last_ready, 1'b1);
    end

    // ADD with an immediate crosses the signed boundary.
    issue(4'd0, 1'b1, 16'h7FFF, 16'h1234, 16'h0001);
    tick();
    chk("add_val", o_val, 16'h8000);
    chk("add_regwen", o_reg, 1'b1);
    chk("add_ccwen", o_ccw, 1'b0);

    // CMP
    issue(4'd3, 1'b0, 16'hFFFF, 16'h0001, 16'h0000);
    tick();
    chk("cmp_neg", o_cc, 3'b100);
    chk("cmp_ccwen", o_ccw, 1'b1);
    chk("cmp_regwen", o_reg, 1'b0);
    issue(4'd3, 1'b0, 16'd5, 16'd5, 16'h0000);
    tick();
    chk("cmp_zero", o_cc, 3'b010);

    // VADD: the lane-0 carry must not reach lane 1.
    vs1 = {16'd3, 16'd2, 16'd1, 16'hFFFF};
    vs2 = {16'd1, 16'd1, 16'd1, 16'd1};
    issue(4'd4, 1'b0, 16'd0, 16'd0, 16'd0);
    tick();
    chk("vadd_val", o_vec, 64'h0004_0003_0002_0000);
    chk("vadd_vwen", o_vreg, 1'b1);

    // MUL 300*300: ready stays low for 3 cycles, result 4 cycles after accept.
    issue(4'd9, 1'b0, 16'd300, 16'd300, 16'd0);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mul_busy_ready", last_ready, 1'b0);
    end
    chk("mul_valid", o_valid, 1'b1);
    chk("mul_val", o_val, 16'h5F90);
    tick();
    chk("mul_ready_after", last_ready, 1'b1);

    // The same MUL with MEM stalling: the result is held for 2 extra cycles.
    issue(4'd9, 1'b1, 16'd300, 16'd0, 16'd300);
    tick();
    idle();
    stall = 1;
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("mulst_hold_val", o_val, 16'h5F90);
      chk("mulst_hold_ready", last_ready, 1'b0);
    end
    stall = 0;
    tick();

    // Branches
    pc = 16'h0010; mask = 3'b010; cc = 3'b010;
    issue(4'd8, 1'b0, 16'd0, 16'd0, 16'hFFF8);
    #1;
    chk("br_target", o_bpc, 16'h0008);
    tick();
    chk("br_taken", last_taken, 1'b1);
    cc = 3'b001;
    issue(4'd8, 1'b0, 16'd0, 16'd0, 16'hFFF8);
    tick();
    chk("br_not_taken", last_taken, 1'b0);
    issue(4'd0, 1'b0, 16'd1, 16'd2, 16'd0);
    tick();
    stall = 1; cc = 3'b010;
    issue(4'd8, 1'b0, 16'd0, 16'd0, 16'hFFF8);
    tick();
    chk("br_stalled", last_taken, 1'b0);
    stall = 0;
    mask = 3'b000; cc = 3'b111;
    issue(4'd8, 1'b0, 16'd0, 16'd0, 16'd4);
    tick();
    chk("br_mask000", last_taken, 1'b0);
    mask = 3'b111; cc = 3'b100;
    issue(4'd8, 1'b0, 16'd0, 16'd0, 16'd4);
    tick();
    chk("br_mask111", last_taken, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      vld    = ($urandom_range(0, 9) < 8);
      op     = 4'($urandom_range(0, 15));
      useimm = 1'($urandom_range(0, 1));
      src1   = 16'($urandom);
      src2   = 16'($urandom);
      imm    = 16'($urandom);
      vs1    = {$urandom, $urandom};
      vs2    = {$urandom, $urandom};
      dest   = 4'($urandom_range(0, 15));
      pc     = 16'($urandom);
      mask   = 3'($urandom_range(0, 7));
      cc     = 3'($urandom_range(0, 7));
      stall  = ($urandom_range(0, 9) < 3);
      tick();
    end
    idle();
    stall = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
